cbc_dec_ctrl: RTL

- Sequencer for the combinational CBC decrypt datapath `cbc_d`.
- Streams a configured number of 128-bit ciphertext blocks through the core over valid/ready handshakes.
- Holds key and IV registers, waits a fixed settle latency, captures plaintext and chains the IV (next IV = current ciphertext).
- Sits between the block stream source/sink and one `cbc_d` instance.

---
 rtl/cbc_dec_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/cbc_dec_ctrl.sv
// cbc_dec_ctrl: streams 128-bit ciphertext blocks through a combinational CBC decrypt core; CBC_DEC_PERF_EN adds stall_cnt
module cbc_dec_ctrl #(
   parameter int CORE_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [127:0]     key_in,
   input  logic [127:0]     iv_in,
   input  logic [CNT_W-1:0] num_blocks,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [127:0]     core_ct,
   output logic [127:0]     core_key,
   output logic [127:0]     core_iv,
   input  logic [127:0]     core_pt,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] blk_cnt
`ifdef CBC_DEC_PERF_EN
   ,output logic [31:0]     stall_cnt
`endif
);
   localparam int LW = $clog2(CORE_LAT + 1);
   typedef enum logic [2:0] {IDLE, ACCEPT, WAIT, OUT, DONE} state_t;
   state_t state, nxt;
   logic [127:0] key_reg, iv_reg, ct_reg;
   logic [CNT_W-1:0] num_reg;
   logic [LW-1:0] cnt;
   logic go, hs_in, hs_out, wait_end, last;
   assign go = state == IDLE && start;
   assign hs_in = in_valid & in_ready;
   assign hs_out = out_valid & out_ready;
   assign wait_end = state == WAIT && cnt == LW'(1);
   assign last = CNT_W'(blk_cnt + 1'b1) == num_reg;
   assign core_ct = ct_reg;
   assign core_key = key_reg;
   assign core_iv = iv_reg;
   assign busy = state != IDLE;
   assign done = state == DONE;
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   // next-state: one block in flight; the core inputs stay frozen through the settle window
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = go ? (num_blocks == '0 ? DONE : ACCEPT) : IDLE;
         ACCEPT:  nxt = hs_in ? WAIT : ACCEPT;
         WAIT:    nxt = wait_end ? OUT : WAIT;
         OUT:     nxt = hs_out ? (last ? DONE : ACCEPT) : OUT;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // datapath: configuration latch, ciphertext capture, plaintext capture and IV chaining
   always_ff @(posedge clk) begin
      if (rst) begin
         key_reg   <= '0;
         iv_reg    <= '0;
         ct_reg    <= '0;
         num_reg   <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         blk_cnt   <= '0;
      end else begin
         in_ready <= nxt == ACCEPT;
         if (go) begin
            key_reg <= key_in;
            iv_reg  <= iv_in;
            num_reg <= num_blocks;
            blk_cnt <= '0;
         end
         if (state == WAIT) cnt <= cnt - 1'b1;
         if (hs_in) begin
            ct_reg <= in_data;
            cnt    <= LW'(CORE_LAT);
         end
         if (wait_end) begin
            out_data  <= core_pt;
            out_valid <= 1'b1;
            iv_reg    <= ct_reg;
         end
         if (hs_out) begin
            out_valid <= 1'b0;
            blk_cnt   <= blk_cnt + 1'b1;
         end
      end
   end
`ifdef CBC_DEC_PERF_EN
   // saturating count of cycles the sink refuses a presented plaintext
   always_ff @(posedge clk) begin
      if (rst || go) stall_cnt <= '0;
      else if (state == OUT && out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end
`endif
endmodule
